// File: rtl/key_matrix_scanner_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | key_matrix_scanner_if                                                    |
// | Keypad pins plus the key report towards the Avalon keypad slave.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface key_matrix_scanner_if;
   logic [3:0] row_i;
   logic [3:0] col_o;
   logic       key_flag;
   logic [3:0] key_value;

   modport master (
      input  row_i,
      output col_o,
      output key_flag,
      output key_value
   );

   modport slave (
      output row_i,
      input  col_o,
      input  key_flag,
      input  key_value
   );
endinterface
`default_nettype wire

// File: rtl/key_matrix_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | key_matrix_scanner                                                       |
// | 4x4 keypad scanner: press debounce, column scan, one-cycle key report.   |
// | Optional auto-repeat enabled by defining KEY_REPEAT_EN.                  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module key_matrix_scanner #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int SETTLE_CYCLES   = 50,
   parameter int REPEAT_DELAY    = 25_000_000,
   parameter int REPEAT_PERIOD   = 5_000_000
) (
   input  logic                 clk,
   input  logic                 reset_n,
   key_matrix_scanner_if.master kp
);

   localparam int c_deb_w = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int c_set_w = $clog2(SETTLE_CYCLES + 1);

   localparam logic [c_deb_w-1:0] c_deb_last = c_deb_w'(DEBOUNCE_CYCLES - 1);
   localparam logic [c_deb_w-1:0] c_deb_one  = c_deb_w'(1);
   localparam logic [c_set_w-1:0] c_set_last = c_set_w'(SETTLE_CYCLES);
   localparam logic [c_set_w-1:0] c_set_one  = c_set_w'(1);

   // The settle window must cover the two-flop row synchronizer delay.
   generate
      if (DEBOUNCE_CYCLES < 1 || SETTLE_CYCLES < 2 ||
          REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_param_check
         $error("key_matrix_scanner: parameter out of range");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_DEB_PRESS = 3'd1,
      S_SCAN      = 3'd2,
      S_REPORT    = 3'd3,
      S_REL_WAIT  = 3'd4
   } state_t;

   state_t               r_state;
   state_t               w_state_next;
   logic [3:0]           r_row_meta;
   logic [3:0]           r_row_sync;
   logic [c_deb_w-1:0]   r_deb_cnt;
   logic [c_deb_w-1:0]   w_deb_cnt_next;
   logic [c_set_w-1:0]   r_set_cnt;
   logic [c_set_w-1:0]   w_set_cnt_next;
   logic [1:0]           r_col;
   logic [1:0]           w_col_next;
   logic [3:0]           r_key_value;
   logic [3:0]           w_key_value_next;
   logic [3:0]           w_col_drive;
   logic                 w_report;
   logic                 w_row_any;
   logic [3:0]           w_row_low;
   logic [2:0]           w_low_cnt;
   logic [1:0]           w_low_idx;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_row_meta <= 4'hF;
         r_row_sync <= 4'hF;
      end else begin
         r_row_meta <= kp.row_i;
         r_row_sync <= r_row_meta;
      end
   end

   assign w_row_any = (r_row_sync != 4'hF);
   assign w_row_low = ~r_row_sync;

   always_comb begin
      w_low_cnt = 3'd0;
      w_low_idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (w_row_low[i]) begin
            w_low_cnt = w_low_cnt + 3'd1;
            w_low_idx = 2'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_deb_cnt   <= '0;
         r_set_cnt   <= '0;
         r_col       <= 2'd0;
         r_key_value <= 4'd0;
      end else begin
         r_state     <= w_state_next;
         r_deb_cnt   <= w_deb_cnt_next;
         r_set_cnt   <= w_set_cnt_next;
         r_col       <= w_col_next;
         r_key_value <= w_key_value_next;
      end
   end

   always_comb begin
      w_state_next     = r_state;
      w_deb_cnt_next   = r_deb_cnt;
      w_set_cnt_next   = r_set_cnt;
      w_col_next       = r_col;
      w_key_value_next = r_key_value;
      w_col_drive      = 4'b0000;
      w_report         = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (w_row_any) w_state_next = S_DEB_PRESS;
         end
         S_DEB_PRESS: begin
            if (!w_row_any)                    w_state_next = S_IDLE;
            else if (r_deb_cnt == c_deb_last)  w_state_next = S_SCAN;
            else                               w_deb_cnt_next = r_deb_cnt + c_deb_one;
         end
         S_SCAN: begin
            w_col_drive = ~(4'b0001 << r_col);
            if (r_set_cnt != c_set_last) begin
               w_set_cnt_next = r_set_cnt + c_set_one;
            end else if (w_low_cnt == 3'd1) begin
               w_state_next     = S_REPORT;
               w_key_value_next = {w_low_idx, r_col};
            end else if (w_low_cnt != 3'd0) begin
               // Ambiguous multi-key hit: wait for a clean release, no report.
               w_state_next = S_REL_WAIT;
            end else if (r_col != 2'd3) begin
               w_col_next     = r_col + 2'd1;
               w_set_cnt_next = '0;
            end else begin
               w_state_next = S_IDLE;
            end
         end
         S_REPORT: begin
            w_report     = 1'b1;
            w_state_next = S_REL_WAIT;
         end
         S_REL_WAIT: begin
            if (w_row_any)                     w_deb_cnt_next = '0;
            else if (r_deb_cnt == c_deb_last)  w_state_next = S_IDLE;
            else                               w_deb_cnt_next = r_deb_cnt + c_deb_one;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase

      if (w_state_next != r_state) begin
         w_deb_cnt_next = '0;
         w_set_cnt_next = '0;
         w_col_next     = 2'd0;
      end
   end

`ifdef KEY_REPEAT_EN
   localparam int c_rep_max = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int c_rep_w   = $clog2(c_rep_max + 1);

   localparam logic [c_rep_w-1:0] c_rep_delay_last  = c_rep_w'(REPEAT_DELAY - 1);
   localparam logic [c_rep_w-1:0] c_rep_period_last = c_rep_w'(REPEAT_PERIOD - 1);
   localparam logic [c_rep_w-1:0] c_rep_one         = c_rep_w'(1);

   logic [c_rep_w-1:0] r_rep_cnt;
   logic               r_rep_first;
   logic               r_rep_active;
   logic               w_rep_held;
   logic               w_rep_pulse;
   logic [c_rep_w-1:0] w_rep_target;

   // With all columns driven, the reported key shows up as its row being low.
   assign w_rep_held   = ~r_row_sync[r_key_value[3:2]];
   assign w_rep_target = r_rep_first ? c_rep_delay_last : c_rep_period_last;
   assign w_rep_pulse  = (r_state == S_REL_WAIT) && r_rep_active && w_rep_held &&
                         (r_rep_cnt == w_rep_target);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rep_cnt    <= '0;
         r_rep_first  <= 1'b1;
         r_rep_active <= 1'b0;
      end else if (r_state != S_REL_WAIT) begin
         r_rep_cnt    <= '0;
         r_rep_first  <= 1'b1;
         r_rep_active <= (r_state == S_REPORT);
      end else if (!w_rep_held) begin
         r_rep_active <= 1'b0;
      end else if (r_rep_active) begin
         if (w_rep_pulse) begin
            r_rep_cnt   <= '0;
            r_rep_first <= 1'b0;
         end else begin
            r_rep_cnt   <= r_rep_cnt + c_rep_one;
         end
      end
   end

   assign kp.key_flag = w_report | w_rep_pulse;
`else
   assign kp.key_flag = w_report;
`endif

   assign kp.col_o     = w_col_drive;
   assign kp.key_value = r_key_value;

endmodule
`default_nettype wire

// File: tb/tb_key_matrix_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_key_matrix_scanner                                                    |
// | Directed and random keypad presses against a press/flag timing model.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_key_matrix_scanner;
   localparam int DEB  = 8;
   localparam int SET  = 2;
   localparam int RDLY = 40;
   localparam int RPER = 16;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] held;       // bit 4*row+col set while that key is pressed
   logic [3:0]  rows;

   key_matrix_scanner_if kp();

   key_matrix_scanner #(
      .DEBOUNCE_CYCLES (DEB),
      .SETTLE_CYCLES   (SET),
      .REPEAT_DELAY    (RDLY),
      .REPEAT_PERIOD   (RPER)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .kp      (kp)
   );

   always #5 clk = ~clk;

   always_comb begin
      rows = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (held[4*r+c] && !kp.col_o[c]) rows[r] = 1'b0;
   end
   assign kp.row_i = rows;

   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;
   int          fl_cyc[$];
   logic [3:0]  fl_val[$];
   bit          col_busy;
   int          exp_off[$];
   logic [3:0]  exp_v;
   logic [3:0]  last_v;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (kp.key_flag === 1'b1) begin
            fl_cyc.push_back(cyc);
            fl_val.push_back(kp.key_value);
         end
         if (kp.col_o !== 4'b0000) col_busy = 1'b1;
      end
   endtask

   // First column with any held key decides; a lone key there reports after
   // sync(2) + idle(1) + debounce + (col+1) settle/sample windows.
   task automatic build_expect(input logic [15:0] keys, input int hold);
      int first_col;
      int nrow;
      int row_of;
      int lat;
      exp_off.delete();
      first_col = -1;
      nrow      = 0;
      row_of    = 0;
      for (int c = 0; c < 4 && first_col < 0; c++)
         for (int r = 0; r < 4; r++)
            if (keys[4*r+c]) first_col = c;
      if (first_col < 0) return;
      for (int r = 0; r < 4; r++)
         if (keys[4*r+first_col]) begin
            nrow++;
            row_of = r;
         end
      if (nrow != 1) return;
      lat = 3 + DEB + (first_col + 1) * (SET + 1);
      if (hold < lat) return;
      exp_off.push_back(lat);
      exp_v = 4'(4 * row_of + first_col);
`ifdef KEY_REPEAT_EN
      for (int t = lat + RDLY; t <= hold + 1; t += RPER) exp_off.push_back(t);
`endif
   endtask

   task automatic trial(input string tag, input logic [15:0] keys, input int hold, input int after);
      int p;
      build_expect(keys, hold);
      fl_cyc.delete();
      fl_val.delete();
      col_busy = 1'b0;
      p    = cyc;
      held = keys;
      tick(hold);
      held = 16'h0000;
      tick(after);
      chk({tag, ":nflags"}, fl_cyc.size(), exp_off.size());
      for (int i = 0; i < exp_off.size() && i < fl_cyc.size(); i++) begin
         chk({tag, ":when"}, fl_cyc[i] - p, exp_off[i]);
         chk({tag, ":value"}, fl_val[i], exp_v);
      end
      if (exp_off.size() > 0) last_v = exp_v;
      if (hold <= DEB) chk({tag, ":no_scan"}, col_busy, 0);
      chk({tag, ":held_value"}, kp.key_value, last_v);
      chk({tag, ":col_idle"}, kp.col_o, 4'b0000);
   endtask

   initial begin
      logic [15:0] keys;
      int          kind;
      int          hold;

      held    = 16'h0000;
      last_v  = 4'd0;
      exp_v   = 4'd0;
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset:col_o", kp.col_o, 4'b0000);
      chk("reset:key_flag", kp.key_flag, 1'b0);
      chk("reset:key_value", kp.key_value, 4'd0);
      reset_n = 1'b1;
      tick(2);

      trial("k12_hold80", 16'h0040, 80, 16);
      trial("k00_short5", 16'h0001, 5, 16);
      trial("multi_01_21", 16'h0202, 40, 16);
      trial("k33_after_multi", 16'h8000, 40, 16);
      trial("k23_early_release", 16'h0800, 15, 16);

      // Reset while the scan is on column 1 with key (1,2) held.
      fl_cyc.delete();
      fl_val.delete();
      held = 16'h0040;
      tick(15);
      chk("rst:scanning_col1", kp.col_o, 4'b1101);
      #2 reset_n = 1'b0;
      #1;
      chk("rst:async_col_o", kp.col_o, 4'b0000);
      chk("rst:async_key_flag", kp.key_flag, 1'b0);
      chk("rst:async_key_value", kp.key_value, 4'd0);
      last_v = 4'd0;
      tick(2);
      chk("rst:flags_during_reset", fl_cyc.size(), 0);
      reset_n = 1'b1;
      trial("rst:rehold", 16'h0040, 40, 16);

      trial("k00_hold104", 16'h0001, 104, 16);

      for (int n = 0; n < 24; n++) begin
         kind = int'($urandom_range(0, 2));
         keys = 16'h0000;
         if (kind == 2) begin
            for (int k = 0; k < int'($urandom_range(2, 3)); k++)
               keys[$urandom_range(0, 15)] = 1'b1;
         end else begin
            keys[$urandom_range(0, 15)] = 1'b1;
         end
         hold = (kind == 0) ? int'($urandom_range(1, 6)) : int'($urandom_range(24, 50));
         trial($sformatf("rand%0d", n), keys, hold, 16);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
